stack_alu_param: RTL and testbench
==================================

Name: stack_alu_param

Overview:
- Parametrised stack-based ALU: operands are pushed onto an internal LIFO of DEPTH words, each N bits wide. Arithmetic ops consume the top two entries and push the result.
- Generalises the fixed push/pop/add/multiply stack ALU. Adds subtract, dup, swap, clear, stack status flags, an op handshake and error reporting.
- Sits between the command sequencer and the result bus; all outputs are registered.

Parameters:
- N, 16, data width in bits; operands and results are signed two's complement.
- DEPTH, 8, stack depth in entries, >= 2.
- CW, $clog2(DEPTH+1), width of the count output (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  opcode/in sampled on a clk edge when high.
- opcode  input  4  operation select.
- in  input  N  push operand.
- out  output  N  result / popped value.
- out_valid  output  1  one-cycle pulse: out holds a new value.
- overflow  output  1  signed arithmetic overflow of the last result.
- err  output  1  one-cycle pulse: illegal op (stack underflow/overflow, undefined opcode).
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  CW  current number of entries.

Behaviour:
- Reset (async, rst_n low): out=0, out_valid=0, overflow=0, err=0, count=0, empty=1, full=0. Stack contents are don't-care. Reset asserted mid-operation aborts that op; no partial update.
- Ops sampled only when op_valid=1. op_valid=0 means no state change; out_valid and err return to 0.
- Latency: one cycle. Effects of an op sampled at edge k are visible after edge k.
- A = top entry, B = second entry.
- Opcodes:
  - 0 NOP.
  - 1 PUSH: in -> top.
  - 2 POP: out=A, drop A.
  - 3 ADD: B+A.
  - 4 SUB: B-A.
  - 5 MUL: B*A.
  - 6 DUP: push copy of A.
  - 7 SWAP: exchange A and B.
  - 8 CLEAR: count=0.
  - 9-15: err=1, no state change.
- Binary ops (ADD/SUB/MUL): pop A and B, push result R (net count -1). out=R, out_valid=1.
- Arithmetic width:
  - R is the low N bits of the exact result.
  - ADD/SUB: overflow=1 iff the signed result is out of N-bit range (operand signs vs result sign rule).
  - MUL: full 2N-bit signed product; overflow=1 iff the product is not representable in N signed bits.
- overflow updates only on ADD/SUB/MUL and holds otherwise. POP sets overflow=0.
- out_valid=1 only after a successful POP/ADD/SUB/MUL. DUP, SWAP, PUSH, CLEAR and NOP leave out unchanged.
- Error conditions: err=1, stack/count/out/overflow unchanged, out_valid=0:
  - PUSH or DUP when full.
  - POP or DUP when empty.
  - ADD/SUB/MUL/SWAP when count < 2.
- CLEAR on an empty stack: legal, no error.
- Stack pointer never wraps. count saturates at the 0 and DEPTH boundaries via the error rules above.

Optional Feature:
- Macro: STACK_ALU_SAT_EN.
- Defined: ADD/SUB/MUL results that overflow are clamped to 2^(N-1)-1 (positive overflow) or -2^(N-1) (negative overflow). The clamped value is pushed and output; overflow is still asserted.
- Undefined: results wrap (low N bits), as described above.

Test Plan (N=16, DEPTH=8):
- Reset: PUSH 5, PUSH 3, assert rst_n low between clk edges -> immediately count=0, empty=1, out=0, out_valid=0. After release, POP -> err=1.
- PUSH 5, PUSH 3, ADD -> out=8, out_valid=1, overflow=0, count=1. POP -> out=8, empty=1.
- PUSH 1, PUSH 2, SUB -> out=0xFFFF (-1), overflow=0. Then PUSH 7, SWAP, POP -> out=0xFFFF. POP -> out=7.
- PUSH 30000, PUSH 30000, ADD -> out=0xEA60, overflow=1. With STACK_ALU_SAT_EN: out=0x7FFF, overflow=1.
- PUSH 300, PUSH 500, MUL -> out=18928 (0x49F0), overflow=1; with STACK_ALU_SAT_EN: out=0x7FFF. PUSH 40, PUSH 30, MUL -> out=1200, overflow=0.
- PUSH 1..8 -> full=1, count=8. PUSH 9 -> err=1, count=8. DUP -> err=1, count=8. POP -> out=8. CLEAR -> empty=1. ADD on empty -> err=1. Opcode 12 -> err=1, state unchanged.

Source files
------------

// File: rtl/stack_alu_param.sv
// stack_alu_param: stack-based ALU with signed N-bit operands and a DEPTH-entry LIFO.
//
// Operations are sampled when op_valid_i is high and take effect on that clock edge.
// Binary ops (ADD/SUB/MUL) replace the top two entries with their result. Illegal
// operations pulse err_o and leave all state unchanged.
//
// Optional build macro:
//   STACK_ALU_SAT_EN - arithmetic results that overflow are clamped to the N-bit signed
//                      maximum or minimum rather than wrapping. overflow_o is still set.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   op_valid_i   qualifies opcode_i / in_i
//   opcode_i     0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 MUL, 6 DUP, 7 SWAP, 8 CLEAR
//   in_i         PUSH operand
//   out_o        result of the last POP/ADD/SUB/MUL
//   out_valid_o  one-cycle pulse when out_o carries a new value
//   overflow_o   signed overflow of the last arithmetic result
//   err_o        one-cycle pulse on an illegal operation
//   empty_o      count_o == 0
//   full_o       count_o == DEPTH
//   count_o      number of stack entries
module stack_alu_param #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid_i,
  input  logic [3:0]    opcode_i,
  input  logic [N-1:0]  in_i,
  output logic [N-1:0]  out_o,
  output logic          out_valid_o,
  output logic          overflow_o,
  output logic          err_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpPush  = 4'd1;
  localparam logic [3:0] OpPop   = 4'd2;
  localparam logic [3:0] OpAdd   = 4'd3;
  localparam logic [3:0] OpSub   = 4'd4;
  localparam logic [3:0] OpMul   = 4'd5;
  localparam logic [3:0] OpDup   = 4'd6;
  localparam logic [3:0] OpSwap  = 4'd7;
  localparam logic [3:0] OpClear = 4'd8;

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [N-1:0]  stack_q [DEPTH];
  logic [N-1:0]  stack_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;
  logic          err_q, err_d;

  logic          is_empty, is_full, lt_two;
  logic [CW-1:0] idx_a, idx_b;
  logic [N-1:0]  a, b;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DepthC);
  assign lt_two   = (count_q < CW'(2));
  // A lives at count-1, B at count-2; only meaningful when the count check passes.
  assign idx_a    = count_q - CW'(1);
  assign idx_b    = count_q - CW'(2);

  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == idx_a) a = stack_q[i];
      if (CW'(i) == idx_b) b = stack_q[i];
    end
  end

  // Arithmetic: sign-extended by one bit for ADD/SUB, full 2N-bit product for MUL.
  logic [N:0]            sum_x, diff_x;
  logic signed [2*N-1:0] prod;
  logic [N:0]            prod_hi;
  logic [N-1:0]          res_raw, res;
  logic                  res_ovf;

  assign sum_x   = {b[N-1], b} + {a[N-1], a};
  assign diff_x  = {b[N-1], b} - {a[N-1], a};
  assign prod    = $signed({{N{b[N-1]}}, b}) * $signed({{N{a[N-1]}}, a});
  assign prod_hi = prod[2*N-1:N-1];

`ifdef STACK_ALU_SAT_EN
  localparam logic [N-1:0] MaxPos = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};
  logic res_neg;  // sign of the exact (unclamped) result
`endif

  always_comb begin
    res_raw = sum_x[N-1:0];
    res_ovf = sum_x[N] ^ sum_x[N-1];
`ifdef STACK_ALU_SAT_EN
    res_neg = sum_x[N];
`endif
    if (opcode_i == OpSub) begin
      res_raw = diff_x[N-1:0];
      res_ovf = diff_x[N] ^ diff_x[N-1];
`ifdef STACK_ALU_SAT_EN
      res_neg = diff_x[N];
`endif
    end else if (opcode_i == OpMul) begin
      res_raw = prod[N-1:0];
      // Representable iff the top N+1 bits are all sign copies.
      res_ovf = !((prod_hi == '0) || (prod_hi == '1));
`ifdef STACK_ALU_SAT_EN
      res_neg = prod[2*N-1];
`endif
    end
`ifdef STACK_ALU_SAT_EN
    res = res_ovf ? (res_neg ? MinNeg : MaxPos) : res_raw;
`else
    res = res_raw;
`endif
  end

  // Next-state decode. Up to two stack writes per op (SWAP needs both).
  logic          wr0_en, wr1_en;
  logic [CW-1:0] wr0_idx, wr1_idx;
  logic [N-1:0]  wr0_data, wr1_data;

  always_comb begin
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    err_d       = 1'b0;
    wr0_en      = 1'b0;
    wr0_idx     = count_q;
    wr0_data    = in_i;
    wr1_en      = 1'b0;
    wr1_idx     = idx_b;
    wr1_data    = a;
    if (op_valid_i) begin
      case (opcode_i)
        OpNop: ;
        OpPush: begin
          if (is_full) begin
            err_d = 1'b1;
          end else begin
            wr0_en  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        OpPop: begin
          if (is_empty) begin
            err_d = 1'b1;
          end else begin
            out_d       = a;
            out_valid_d = 1'b1;
            overflow_d  = 1'b0;
            count_d     = idx_a;
          end
        end
        OpAdd, OpSub, OpMul: begin
          if (lt_two) begin
            err_d = 1'b1;
          end else begin
            wr0_en      = 1'b1;
            wr0_idx     = idx_b;
            wr0_data    = res;
            out_d       = res;
            out_valid_d = 1'b1;
            overflow_d  = res_ovf;
            count_d     = idx_a;
          end
        end
        OpDup: begin
          if (is_empty || is_full) begin
            err_d = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_data = a;
            count_d  = count_q + CW'(1);
          end
        end
        OpSwap: begin
          if (lt_two) begin
            err_d = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_idx  = idx_a;
            wr0_data = b;
            wr1_en   = 1'b1;
          end
        end
        OpClear: count_d = '0;
        default: err_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (wr0_en && (CW'(i) == wr0_idx)) stack_d[i] = wr0_data;
      if (wr1_en && (CW'(i) == wr1_idx)) stack_d[i] = wr1_data;
    end
  end

  // Stack contents are don't-care after reset, so the storage has no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign overflow_o  = overflow_q;
  assign err_o       = err_q;
  assign count_o     = count_q;
  assign empty_o     = is_empty;
  assign full_o      = is_full;

endmodule

// File: tb/tb_stack_alu_param.sv
// Testbench for stack_alu_param (N=16, DEPTH=8): a table of operations with expected
// outputs, fed through a scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_stack_alu_param;

  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, POP = 4'd2, ADD = 4'd3, SUB = 4'd4;
  localparam logic [3:0] MUL = 4'd5, DUP = 4'd6, SWAP = 4'd7, CLR = 4'd8, BAD = 4'd12;

`ifdef STACK_ALU_SAT_EN
  localparam logic [15:0] AddPosOvf = 16'h7FFF;  // 30000 + 30000
  localparam logic [15:0] MulPosOvf = 16'h7FFF;  // 300 * 500
  localparam logic [15:0] SubNegOvf = 16'h8000;  // -32768 - 1
  localparam logic [15:0] MulNegOvf = 16'h8000;  // -300 * 500
`else
  localparam logic [15:0] AddPosOvf = 16'hEA60;
  localparam logic [15:0] MulPosOvf = 16'h49F0;
  localparam logic [15:0] SubNegOvf = 16'h7FFF;
  localparam logic [15:0] MulNegOvf = 16'hB610;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic [3:0]    opcode = '0;
  logic [N-1:0]  din = '0;
  logic [N-1:0]  out;
  logic          out_valid, overflow, err, empty, full;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  stack_alu_param #(.N(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid_i  (op_valid),
    .opcode_i    (opcode),
    .in_i        (din),
    .out_o       (out),
    .out_valid_o (out_valid),
    .overflow_o  (overflow),
    .err_o       (err),
    .empty_o     (empty),
    .full_o      (full),
    .count_o     (count)
  );

  typedef struct {
    logic        vld;
    logic [3:0]  op;
    logic [15:0] din;
    logic [15:0] out;
    logic        ov;
    logic        ovf;
    logic        err;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [3:0] op, input logic [15:0] d,
                     input logic [15:0] o, input logic ov, input logic ovf, input logic e,
                     input logic [3:0] c);
    vec_t v;
    v.vld = vld; v.op = op; v.din = d; v.out = o; v.ov = ov; v.ovf = ovf; v.err = e;
    v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic check_state(input string tag, input vec_t e);
    vectors++;
    chk({tag, " out"}, 32'(out), 32'(e.out));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e.ov));
    chk({tag, " overflow"}, 32'(overflow), 32'(e.ovf));
    chk({tag, " err"}, 32'(err), 32'(e.err));
    chk({tag, " count"}, 32'(count), 32'(e.cnt));
    chk({tag, " empty"}, 32'(empty), 32'(e.cnt == 4'd0));
    chk({tag, " full"}, 32'(full), 32'(e.cnt == 4'(DEPTH)));
  endtask

  // Drive on the falling edge, sample 1 ns after the rising edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    op_valid = v.vld;
    opcode   = v.op;
    din      = v.din;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_state(tag, e);
  endtask

  initial begin
    vec_t r;
    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    r = '{vld: 1'b0, op: NOP, din: 16'h0, out: 16'h0, ov: 1'b0, ovf: 1'b0, err: 1'b0,
          cnt: 4'd0};
    check_state("por", r);
    @(negedge clk);
    rst_n = 1'b1;

    // Build state, then assert reset between edges: it must clear immediately.
    add(1, PUSH, 16'd5, 16'h0, 0, 0, 0, 4'd1);
    add(1, PUSH, 16'd3, 16'h0, 0, 0, 0, 4'd2);
    add(1, ADD, 16'h0, 16'h0008, 1, 0, 0, 4'd1);
    foreach (tbl[i]) apply(tbl[i], $sformatf("pre%0d", i));
    tbl.delete();
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", r);
    // An op presented while reset is held must not take effect.
    @(negedge clk);
    op_valid = 1'b1;
    opcode   = PUSH;
    din      = 16'd99;
    @(posedge clk);
    #1;
    check_state("rst_held", r);
    @(negedge clk);
    op_valid = 1'b0;
    rst_n    = 1'b1;

    // vld, op, din, out, out_valid, overflow, err, count
    add(1, POP,  16'h0,    16'h0000, 0, 0, 1, 4'd0);
    add(1, PUSH, 16'd5,    16'h0000, 0, 0, 0, 4'd1);
    add(1, PUSH, 16'd3,    16'h0000, 0, 0, 0, 4'd2);
    add(1, ADD,  16'h0,    16'h0008, 1, 0, 0, 4'd1);
    add(1, POP,  16'h0,    16'h0008, 1, 0, 0, 4'd0);
    add(1, PUSH, 16'd1,    16'h0008, 0, 0, 0, 4'd1);
    add(1, PUSH, 16'd2,    16'h0008, 0, 0, 0, 4'd2);
    add(1, SUB,  16'h0,    16'hFFFF, 1, 0, 0, 4'd1);
    add(1, PUSH, 16'd7,    16'hFFFF, 0, 0, 0, 4'd2);
    add(1, SWAP, 16'h0,    16'hFFFF, 0, 0, 0, 4'd2);
    add(1, POP,  16'h0,    16'hFFFF, 1, 0, 0, 4'd1);
    add(1, POP,  16'h0,    16'h0007, 1, 0, 0, 4'd0);
    add(1, PUSH, 16'd30000, 16'h0007, 0, 0, 0, 4'd1);
    add(1, PUSH, 16'd30000, 16'h0007, 0, 0, 0, 4'd2);
    add(1, ADD,  16'h0,    AddPosOvf, 1, 1, 0, 4'd1);
    add(1, POP,  16'h0,    AddPosOvf, 1, 0, 0, 4'd0);
    add(1, PUSH, 16'd300,  AddPosOvf, 0, 0, 0, 4'd1);
    add(1, PUSH, 16'd500,  AddPosOvf, 0, 0, 0, 4'd2);
    add(1, MUL,  16'h0,    MulPosOvf, 1, 1, 0, 4'd1);
    add(1, PUSH, 16'd40,   MulPosOvf, 0, 1, 0, 4'd2);
    add(1, PUSH, 16'd30,   MulPosOvf, 0, 1, 0, 4'd3);
    add(1, MUL,  16'h0,    16'd1200,  1, 0, 0, 4'd2);
    add(1, NOP,  16'h0,    16'd1200,  0, 0, 0, 4'd2);
    add(1, CLR,  16'h0,    16'd1200,  0, 0, 0, 4'd0);
    for (int k = 1; k <= 8; k++) add(1, PUSH, 16'(k), 16'd1200, 0, 0, 0, 4'(k));
    add(1, PUSH, 16'd9,    16'd1200,  0, 0, 1, 4'd8);
    add(1, DUP,  16'h0,    16'd1200,  0, 0, 1, 4'd8);
    add(1, POP,  16'h0,    16'h0008,  1, 0, 0, 4'd7);
    add(1, DUP,  16'h0,    16'h0008,  0, 0, 0, 4'd8);
    add(1, POP,  16'h0,    16'h0007,  1, 0, 0, 4'd7);
    add(1, CLR,  16'h0,    16'h0007,  0, 0, 0, 4'd0);
    add(1, ADD,  16'h0,    16'h0007,  0, 0, 1, 4'd0);
    add(1, DUP,  16'h0,    16'h0007,  0, 0, 1, 4'd0);
    add(1, PUSH, 16'd4,    16'h0007,  0, 0, 0, 4'd1);
    add(1, SWAP, 16'h0,    16'h0007,  0, 0, 1, 4'd1);
    add(1, BAD,  16'h0,    16'h0007,  0, 0, 1, 4'd1);
    add(0, PUSH, 16'd55,   16'h0007,  0, 0, 0, 4'd1);
    add(1, POP,  16'h0,    16'h0004,  1, 0, 0, 4'd0);
    add(1, CLR,  16'h0,    16'h0004,  0, 0, 0, 4'd0);
    add(1, PUSH, 16'h8000, 16'h0004,  0, 0, 0, 4'd1);
    add(1, PUSH, 16'h0001, 16'h0004,  0, 0, 0, 4'd2);
    add(1, SUB,  16'h0,    SubNegOvf, 1, 1, 0, 4'd1);
    add(1, POP,  16'h0,    SubNegOvf, 1, 0, 0, 4'd0);
    add(1, PUSH, 16'hFED4, SubNegOvf, 0, 0, 0, 4'd1);
    add(1, PUSH, 16'h01F4, SubNegOvf, 0, 0, 0, 4'd2);
    add(1, MUL,  16'h0,    MulNegOvf, 1, 1, 0, 4'd1);
    add(1, ADD,  16'h0,    MulNegOvf, 0, 1, 1, 4'd1);
    add(1, POP,  16'h0,    MulNegOvf, 1, 0, 0, 4'd0);

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    @(negedge clk);
    op_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
